// File: rtl/rv32im_lat_mem.sv
// Word-addressed RV32 data memory with fixed response latency, an outstanding-request cap
// and optional periodic accept stalls. Responses return in order through a shift pipeline.
module rv32im_lat_mem #(
    parameter int unsigned DEPTH_WORDS     = 16384,
    parameter logic [31:0] BASE_ADDR       = 32'h80000000,
    parameter int unsigned LATENCY         = 2,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned STALL_EVERY     = 0,
    parameter int unsigned TAG_W           = 11,
    parameter string       INIT_FILE       = ""
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_rd_i,
    input  logic [3:0]       req_wr_i,
    input  logic [31:0]      req_addr_i,
    input  logic [31:0]      req_data_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic             req_accept_o,
    output logic             resp_ack_o,
    output logic [31:0]      resp_data_o,
    output logic [TAG_W-1:0] resp_tag_o,
    output logic             resp_error_o
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned SW = (STALL_EVERY > 1) ? $clog2(STALL_EVERY) : 1;
    localparam logic [SW-1:0] STALL_LAST = SW'((STALL_EVERY == 0) ? 0 : STALL_EVERY - 1);

    logic [31:0] mem [DEPTH_WORDS];

    logic [OW-1:0]      outst_q;
    logic [SW-1:0]      scnt_q;
    logic               stall_q;
    logic [LATENCY-1:0] pv_q;
    logic [LATENCY-1:0] perr_q;
    logic [31:0]        pdata_q [LATENCY];
    logic [TAG_W-1:0]   ptag_q  [LATENCY];

    logic        wr_req;
    logic        fire;
    logic        bad;
    logic [31:0] offs;
    logic [31:0] widx;
    logic [AW-1:0] mem_idx;
    logic [31:0] rd_word;

    assign wr_req       = |req_wr_i;
    assign req_accept_o = (outst_q < OW'(MAX_OUTSTANDING)) && !stall_q;
    assign fire         = (req_rd_i || wr_req) && req_accept_o;

    // Below-base addresses wrap to huge offsets, but the explicit compare keeps intent clear.
    assign offs    = req_addr_i - BASE_ADDR;
    assign widx    = offs >> 2;
    assign mem_idx = widx[AW-1:0];
    assign bad     = (req_addr_i < BASE_ADDR) || (req_addr_i[1:0] != 2'b00) ||
                     (widx >= DEPTH_WORDS) || (req_rd_i && wr_req);
    assign rd_word = (req_rd_i && !bad) ? mem[mem_idx] : 32'h0;

    always_ff @(posedge clk) begin
        if (fire && wr_req && !bad) begin
            for (int i = 0; i < 4; i++) begin
                if (req_wr_i[i]) mem[mem_idx][8*i +: 8] <= req_data_i[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv_q   <= '0;
            perr_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pdata_q[i] <= '0;
                ptag_q[i]  <= '0;
            end
        end else begin
            pv_q[0]    <= fire;
            perr_q[0]  <= fire && bad;
            pdata_q[0] <= fire ? rd_word : 32'h0;
            ptag_q[0]  <= fire ? req_tag_i : '0;
            for (int i = 1; i < LATENCY; i++) begin
                pv_q[i]    <= pv_q[i-1];
                perr_q[i]  <= perr_q[i-1];
                pdata_q[i] <= pdata_q[i-1];
                ptag_q[i]  <= ptag_q[i-1];
            end
        end
    end

    assign resp_ack_o   = pv_q[LATENCY-1];
    assign resp_error_o = perr_q[LATENCY-1];
    assign resp_data_o  = pdata_q[LATENCY-1];
    assign resp_tag_o   = ptag_q[LATENCY-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outst_q <= '0;
            scnt_q  <= '0;
            stall_q <= 1'b0;
        end else begin
            if (fire && !resp_ack_o) begin
                outst_q <= outst_q + 1'b1;
            end else if (!fire && resp_ack_o) begin
                outst_q <= outst_q - 1'b1;
            end
            // The stall flag lives for exactly one cycle after the Nth accepted request.
            if (STALL_EVERY != 0 && fire) begin
                if (scnt_q == STALL_LAST) begin
                    scnt_q  <= '0;
                    stall_q <= 1'b1;
                end else begin
                    scnt_q  <= scnt_q + 1'b1;
                    stall_q <= 1'b0;
                end
            end else begin
                stall_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rv32im_lat_mem.sv
// Bench for rv32im_lat_mem: three configurations exercised one at a time against a
// transaction-level model (response queue with due cycles, byte-array memory).
module tb_rv32im_lat_mem;

    localparam logic [31:0] BASE   = 32'h80000000;
    localparam longint      BASE_L = 64'h80000000;
    localparam int          DEPTH  = 64;

    typedef struct {
        int          due;
        logic [10:0] tag;
        logic        err;
        logic        dchk;
        logic [31:0] data;
        logic        tchk;
        logic        terr;
        logic [31:0] tdata;
    } exp_t;

    typedef struct {
        logic        rd;
        logic [3:0]  wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [10:0] tag;
        logic        eerr;
        logic [31:0] edata;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_rd    [3];
    logic [3:0]  s_wr    [3];
    logic [31:0] s_addr  [3];
    logic [31:0] s_wdata [3];
    logic [10:0] s_tag   [3];
    logic        o_acc   [3];
    logic        o_ack   [3];
    logic [31:0] o_rdata [3];
    logic [10:0] o_rtag  [3];
    logic        o_err   [3];

    int n_pass = 0;
    int n_total = 0;
    int cur = 0;
    int t = 0;
    int nfire = 0;
    logic stall_nxt = 1'b0;
    exp_t q[$];
    logic [31:0] mm [DEPTH];
    logic        mv [DEPTH];

    always #5 clk = ~clk;

    rv32im_lat_mem #(.DEPTH_WORDS(DEPTH), .LATENCY(2), .MAX_OUTSTANDING(4), .STALL_EVERY(0)) u_a (
        .clk(clk), .rst_n(rst_n), .req_rd_i(s_rd[0]), .req_wr_i(s_wr[0]), .req_addr_i(s_addr[0]),
        .req_data_i(s_wdata[0]), .req_tag_i(s_tag[0]), .req_accept_o(o_acc[0]),
        .resp_ack_o(o_ack[0]), .resp_data_o(o_rdata[0]), .resp_tag_o(o_rtag[0]),
        .resp_error_o(o_err[0]));

    rv32im_lat_mem #(.DEPTH_WORDS(DEPTH), .LATENCY(4), .MAX_OUTSTANDING(2), .STALL_EVERY(0)) u_b (
        .clk(clk), .rst_n(rst_n), .req_rd_i(s_rd[1]), .req_wr_i(s_wr[1]), .req_addr_i(s_addr[1]),
        .req_data_i(s_wdata[1]), .req_tag_i(s_tag[1]), .req_accept_o(o_acc[1]),
        .resp_ack_o(o_ack[1]), .resp_data_o(o_rdata[1]), .resp_tag_o(o_rtag[1]),
        .resp_error_o(o_err[1]));

    rv32im_lat_mem #(.DEPTH_WORDS(DEPTH), .LATENCY(4), .MAX_OUTSTANDING(8), .STALL_EVERY(3)) u_c (
        .clk(clk), .rst_n(rst_n), .req_rd_i(s_rd[2]), .req_wr_i(s_wr[2]), .req_addr_i(s_addr[2]),
        .req_data_i(s_wdata[2]), .req_tag_i(s_tag[2]), .req_accept_o(o_acc[2]),
        .resp_ack_o(o_ack[2]), .resp_data_o(o_rdata[2]), .resp_tag_o(o_rtag[2]),
        .resp_error_o(o_err[2]));

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : 4;
    endfunction

    function automatic int max_of(input int k);
        return (k == 0) ? 4 : ((k == 1) ? 2 : 8);
    endfunction

    function automatic int stl_of(input int k);
        return (k == 2) ? 3 : 0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s (inst %0d, cycle %0d): got %h want %h", nm, cur, t, act, exp);
    endtask

    task automatic step(input logic i_rd, input logic [3:0] i_wr, input logic [31:0] i_a,
                        input logic [31:0] i_d, input logic [10:0] i_tag,
                        input logic tchk, input logic terr, input logic [31:0] tdata);
        exp_t   e;
        logic   ea;
        logic   fire;
        logic   bad;
        longint la;
        int     wi;
        @(negedge clk);
        t++;
        ea = (q.size() < max_of(cur)) && !stall_nxt;
        chk("accept", 32'(o_acc[cur]), 32'(ea));
        if (q.size() != 0 && q[0].due == t) begin
            e = q.pop_front();
            chk("ack", 32'(o_ack[cur]), 32'd1);
            chk("resp_tag", 32'(o_rtag[cur]), 32'(e.tag));
            chk("resp_err", 32'(o_err[cur]), 32'(e.err));
            if (e.dchk) chk("resp_data", o_rdata[cur], e.data);
            if (e.tchk) begin
                chk("vec_err", 32'(o_err[cur]), 32'(e.terr));
                chk("vec_data", o_rdata[cur], e.tdata);
            end
        end else begin
            chk("no_ack", 32'(o_ack[cur]), 32'd0);
            chk("idle_data", o_rdata[cur], 32'd0);
        end
        for (int k = 0; k < 3; k++) begin
            s_rd[k] = 1'b0;
            s_wr[k] = 4'h0;
        end
        s_rd[cur] = i_rd;
        s_wr[cur] = i_wr;
        s_addr[cur] = i_a;
        s_wdata[cur] = i_d;
        s_tag[cur] = i_tag;
        fire = ea && (i_rd || i_wr != 4'h0);
        stall_nxt = 1'b0;
        if (fire) begin
            nfire++;
            if (stl_of(cur) > 0 && (nfire % stl_of(cur)) == 0) stall_nxt = 1'b1;
            la = longint'(i_a);
            bad = (la < BASE_L) || (la >= BASE_L + 4 * DEPTH) || (i_a % 4 != 0) ||
                  (i_rd && i_wr != 4'h0);
            e.due = t + lat_of(cur);
            e.tag = i_tag;
            e.err = bad;
            e.tchk = tchk;
            e.terr = terr;
            e.tdata = tdata;
            e.dchk = 1'b1;
            e.data = 32'h0;
            if (!bad) begin
                wi = int'((la - BASE_L) / 4);
                if (i_rd) begin
                    e.dchk = mv[wi];
                    e.data = mm[wi];
                end else begin
                    for (int b = 0; b < 4; b++) begin
                        if (i_wr[b]) mm[wi][8*b +: 8] = i_d[8*b +: 8];
                    end
                    if (i_wr == 4'hF) mv[wi] = 1'b1;
                end
            end
            q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'h0, BASE, 32'h0, 11'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic select(input int k);
        idle(6);
        q.delete();
        cur = k;
        nfire = 0;
        stall_nxt = 1'b0;
        for (int i = 0; i < DEPTH; i++) mv[i] = 1'b0;
    endtask

    vec_t vecs[12];

    initial begin
        logic [31:0] a;
        logic [3:0]  w;
        int          r;
        int          sel;
        int          guard;

        vecs[0]  = '{1'b0, 4'hF, 32'h80000010, 32'hDEADBEEF, 11'd5,  1'b0, 32'h0};
        vecs[1]  = '{1'b1, 4'h0, 32'h80000010, 32'h0,        11'd6,  1'b0, 32'hDEADBEEF};
        vecs[2]  = '{1'b0, 4'hF, 32'h80000020, 32'h11223344, 11'd7,  1'b0, 32'h0};
        vecs[3]  = '{1'b0, 4'h2, 32'h80000020, 32'h0000AB00, 11'd8,  1'b0, 32'h0};
        vecs[4]  = '{1'b1, 4'h0, 32'h80000020, 32'h0,        11'd9,  1'b0, 32'h1122AB44};
        vecs[5]  = '{1'b1, 4'h0, 32'h7FFFFFFC, 32'h0,        11'd10, 1'b1, 32'h0};
        vecs[6]  = '{1'b1, 4'h0, 32'h80000002, 32'h0,        11'd11, 1'b1, 32'h0};
        vecs[7]  = '{1'b1, 4'h0, 32'h80000100, 32'h0,        11'd12, 1'b1, 32'h0};
        vecs[8]  = '{1'b1, 4'hF, 32'h80000010, 32'h0,        11'd13, 1'b1, 32'h0};
        vecs[9]  = '{1'b1, 4'h0, 32'h80000010, 32'h0,        11'd14, 1'b0, 32'hDEADBEEF};
        vecs[10] = '{1'b0, 4'hF, 32'h800000FC, 32'hA5A50F0F, 11'd15, 1'b0, 32'h0};
        vecs[11] = '{1'b1, 4'h0, 32'h800000FC, 32'h0,        11'd16, 1'b0, 32'hA5A50F0F};

        for (int k = 0; k < 3; k++) begin
            s_rd[k] = 1'b0;
            s_wr[k] = 4'h0;
            s_addr[k] = BASE;
            s_wdata[k] = 32'h0;
            s_tag[k] = 11'h0;
        end
        for (int i = 0; i < DEPTH; i++) mv[i] = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_accept", 32'(o_acc[0]), 32'd1);
        chk("rst_ack", 32'(o_ack[0]), 32'd0);
        chk("rst_data", o_rdata[0], 32'd0);
        chk("rst_tag", 32'(o_rtag[0]), 32'd0);
        chk("rst_err", 32'(o_err[0]), 32'd0);
        rst_n = 1'b1;

        // Directed vectors on the default-latency instance, issued back to back.
        for (int i = 0; i < 12; i++) begin
            step(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].tag,
                 1'b1, vecs[i].eerr, vecs[i].edata);
        end
        idle(4);

        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 4'hF, BASE + 32'(4 * i), $urandom, 11'(i), 1'b0, 1'b0, 32'h0);
        end

        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            sel = $urandom_range(0, 19);
            a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
            if (sel == 0) a = BASE - 32'd4;
            else if (sel == 1) a = a | 32'($urandom_range(1, 3));
            else if (sel == 2) a = BASE + 32'(4 * DEPTH);
            else if (sel == 3) a = $urandom;
            w = 4'($urandom_range(1, 15));
            if (r < 3) step(1'b0, 4'h0, a, $urandom, 11'($urandom), 1'b0, 1'b0, 32'h0);
            else if (r < 6) step(1'b1, 4'h0, a, $urandom, 11'($urandom), 1'b0, 1'b0, 32'h0);
            else if (r < 9) step(1'b0, w, a, $urandom, 11'($urandom), 1'b0, 1'b0, 32'h0);
            else step(1'b1, w, a, $urandom, 11'($urandom), 1'b0, 1'b0, 32'h0);
        end

        // Outstanding cap: continuous reads against MAX_OUTSTANDING=2, LATENCY=4.
        select(1);
        for (int i = 0; i < 24; i++) step(1'b1, 4'h0, BASE, 32'h0, 11'(i), 1'b0, 1'b0, 32'h0);

        // Periodic stall: continuous reads should see accept 1,1,1,0.
        select(2);
        for (int i = 0; i < 16; i++) step(1'b1, 4'h0, BASE + 32'd4, 32'h0, 11'(i), 1'b0, 1'b0, 32'h0);
        idle(6);

        // Reset with requests in flight: no late acks, storage retained.
        step(1'b0, 4'hF, BASE + 32'd8, 32'h12345678, 11'd100, 1'b1, 1'b0, 32'h0);
        idle(6);
        guard = 0;
        while (q.size() < 3 && guard < 10) begin
            step(1'b1, 4'h0, BASE + 32'd8, 32'h0, 11'(200 + guard), 1'b0, 1'b0, 32'h0);
            guard++;
        end
        idle(1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_accept", 32'(o_acc[2]), 32'd1);
        chk("mid_rst_ack", 32'(o_ack[2]), 32'd0);
        chk("mid_rst_data", o_rdata[2], 32'd0);
        chk("mid_rst_tag", 32'(o_rtag[2]), 32'd0);
        chk("mid_rst_err", 32'(o_err[2]), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        nfire = 0;
        stall_nxt = 1'b0;
        idle(8);
        step(1'b1, 4'h0, BASE + 32'd8, 32'h0, 11'd300, 1'b1, 1'b0, 32'h12345678);
        idle(6);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
